fpalu_issue_arbiter: RTL
========================

// Module: fpalu_issue_arbiter
// PURPOSE
//  Shares one pipelined FPALU (FP29i add/mul) between NREQ requesters, e.g. the FIR tap sequencer and a host/debug port.
//  Round-robin grant, one issue per clock, registered operand/opcode launch, and a tag pipeline that routes each result back as a one-cycle rsp_valid.
//  Also drives the ALU clock-enable (idle => gated) and provides a drain/flush handshake.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  ALU_LAT  4   clocks from registered ALU inputs to valid alu_y
//  DW       29  FP29i operand width {s,e[5:0],m[21:0]}
// PORTS
//  clk         in   1        single clock, all state on posedge
//  rst         in   1        asynchronous, active-high reset
//  req_valid   in   NREQ     requester i has an operation pending
//  req_ready   out  NREQ     one-hot issue acknowledge (combinational)
//  req_op      in   2*NREQ   opcode per requester (2'b10 MUL16, 2'b11 ADD29)
//  req_a       in   DW*NREQ  operand A per requester
//  req_b       in   DW*NREQ  operand B per requester
//  req_lock    in   NREQ     hold grant for back-to-back chain (FPARB_LOCK_EN only)
//  flush       in   1        stop issuing, drain pipeline
//  flush_done  out  1        pipeline empty while flush high
//  alu_op      out  2        registered opcode to FPALU
//  alu_a       out  DW       registered operand A
//  alu_b       out  DW       registered operand B
//  alu_clk_en  out  1        enable for ALU clock gate
//  alu_y       in   DW       FPALU result
//  rsp_valid   out  NREQ     one-hot, 1 cycle: rsp_y belongs to requester i
//  rsp_y       out  DW       alu_y passed through
// BEHAVIOUR
//  - Reset: req_ready=0, alu_op/alu_a/alu_b=0, alu_clk_en=0, rsp_valid=0, flush_done=0.
//    RR pointer = NREQ-1, so requester 0 wins first. Tag pipe cleared. State = S_ARB.
//  - Handshake: issue occurs when req_valid[i] & req_ready[i] at posedge.
//    Requester holds valid/op/a/b stable until ready. Valid is never withdrawn before ready.
//  - Grant: in S_ARB, ready goes to the first valid index after the RR pointer (circular).
//    The pointer moves to the granted index only on issue. Idle cycles keep the pointer.
//  - Issue at edge T: alu_op/a/b are registered at T. The tag {vld,idx} enters tag pipe stage 0.
//    rsp_valid[idx] is high in the cycle ALU_LAT clocks after T, with rsp_y = alu_y.
//    Throughput is 1 op/clk. Opcodes 00/01 are forwarded unchanged and still get a rsp.
//  - alu_clk_en = issue this cycle | any tag-pipe stage valid. It is 0 after the last response retires.
//  - FSM: S_ARB -> S_LOCK (issue with req_lock[i], macro on) -> S_ARB on issue with req_lock[i]=0.
//    S_ARB/S_LOCK -> S_DRAIN on flush. S_DRAIN -> S_ARB when flush=0.
//  - S_LOCK: only the locked index may receive ready. Other requesters stall even if valid.
//  - S_DRAIN: req_ready=0. In-flight ops still complete and respond.
//    flush_done=1 when the tag pipe is empty and flush=1. Flush asserted while empty gives flush_done next cycle.
//  - Simultaneous flush and issue: the issue completes, then S_DRAIN.
//  - Reset mid-operation: in-flight tags are discarded and no rsp_valid follows.
// CONFIGURATION
//  FPARB_LOCK_EN defined: req_lock honoured and S_LOCK exists (FIR accumulate chains keep the ALU).
//  FPARB_LOCK_EN undefined: req_lock ignored (may be tied 0) and S_LOCK unreachable/absent. Pure round-robin.
// STRUCTURE
//  fir_pkg holds shared definitions:
//   - FP29I_W=29 and the field offsets.
//   - OP_MUL16=2'b10, OP_ADD29=2'b11.
//   - ALU_LAT default.
//   - FSM state encodings S_ARB/S_LOCK/S_DRAIN.
//  Sub-module fpalu_rr_arbiter: combinational RR grant from valid vector + pointer; pointer register stays in the parent.
//  Parent holds FSM, operand launch registers, tag shift pipe (ALU_LAT deep), rsp decode.
// TESTING
//  1) Reset, idle 10 clk -> all outputs 0, alu_clk_en=0.
//  2) Both valid continuously, 8 ops each -> grants alternate 0,1,0,1...
//     Each rsp_valid arrives exactly 4 clk after its issue with the matching alu_y.
//  3) Req1 issues ADD29 with req_lock=1 for 5 ops while req0 valid (LOCK_EN) -> req1 gets 5 back-to-back grants, req0 waits, then req0 granted.
//     Same test without the macro -> alternation.
//  4) flush raised with 3 ops in flight -> req_ready=0 at once; 3 rsp_valid follow; flush_done high 1 clk after the last rsp.
//  5) rst pulsed 2 clk after an issue -> no rsp_valid in the next 8 clk; first grant after reset goes to req0.
//  6) NREQ=3, only req2 valid, 4 ops -> 4 consecutive grants to req2; alu_clk_en drops 4 clk after the last issue.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath: FP29i layout, FPALU opcodes,
// default ALU latency and the issue-arbiter state encoding.
package fir_pkg;

    localparam int FP29I_W  = 29;
    localparam int FP_M_LSB = 0;
    localparam int FP_M_W   = 22;
    localparam int FP_E_LSB = 22;
    localparam int FP_E_W   = 6;
    localparam int FP_S_BIT = 28;

    localparam logic [1:0] OP_MUL16 = 2'b10;
    localparam logic [1:0] OP_ADD29 = 2'b11;

    localparam int ALU_LAT_DEF = 4;

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_LOCK  = 2'd1,
        S_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fpalu_rr_arbiter.sv
// Combinational round-robin grant: first valid index strictly after ptr,
// wrapping circularly. The pointer register lives in the parent.
module fpalu_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [IW:0]   cand_s;
    logic [IW-1:0] idx_s;
    logic          hit_s;
    logic          found_s;

    // Scan candidates ptr+1 .. ptr+NREQ (mod NREQ), first valid wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            cand_s    = {1'b0, ptr} + (IW+1)'(off);
            cand_s    = (cand_s >= (IW+1)'(NREQ)) ? cand_s - (IW+1)'(NREQ) : cand_s;
            idx_s     = cand_s[IW-1:0];
            hit_s     = valid[idx_s] & ~found_s;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx = hit_s ? idx_s : grant_idx;
            found_s   = found_s | hit_s;
        end
    end

endmodule

// File: rtl/fpalu_issue_arbiter.sv
// Shares one pipelined FPALU between NREQ requesters: RR issue, operand launch,
// tag pipe for response routing, ALU clock enable and drain/flush.
// Optional macro FPARB_LOCK_EN enables req_lock grant holding (S_LOCK).
module fpalu_issue_arbiter
    import fir_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = ALU_LAT_DEF,
    parameter int DW      = FP29I_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [DW*NREQ-1:0] req_a,
    input  logic [DW*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]   req_lock,
    input  logic              flush,
    output logic              flush_done,
    output logic [1:0]        alu_op,
    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic              alu_clk_en,
    input  logic [DW-1:0]     alu_y,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_y
);

    localparam int IW = $clog2(NREQ);

    arb_state_e      state_r;
    logic [IW-1:0]   ptr_r;
    logic [NREQ-1:0] arb_grant_s;
    logic [IW-1:0]   arb_idx_s;
    logic [NREQ-1:0] ready_s;
    logic            issue_s;
    logic [IW-1:0]   issue_idx_s;

    logic [1:0]      alu_op_r;
    logic [DW-1:0]   alu_a_r;
    logic [DW-1:0]   alu_b_r;
    logic [ALU_LAT-1:0] tag_vld_r;
    logic [IW-1:0]   tag_idx_r [ALU_LAT];
    logic [NREQ-1:0] rsp_valid_r;
    logic            flush_done_r;

    logic [1:0]      op_arr_s [NREQ];
    logic [DW-1:0]   a_arr_s  [NREQ];
    logic [DW-1:0]   b_arr_s  [NREQ];

`ifdef FPARB_LOCK_EN
    logic [IW-1:0]   lock_idx_r;
`else
    logic            unused_lock_s;
    assign unused_lock_s = ^req_lock;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr_s[g] = req_op[g*2 +: 2];
        assign a_arr_s[g]  = req_a[g*DW +: DW];
        assign b_arr_s[g]  = req_b[g*DW +: DW];
    end

    fpalu_rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    // Ready source per state; a locked chain only ever acknowledges its owner
    always_comb begin
        ready_s = '0;
        case (state_r)
            S_ARB:   ready_s = arb_grant_s;
`ifdef FPARB_LOCK_EN
            S_LOCK:  ready_s = req_valid & (NREQ'(1'b1) << lock_idx_r);
`endif
            S_DRAIN: ready_s = '0;
            default: ready_s = '0;
        endcase
    end

    assign req_ready = ready_s & {NREQ{~rst}};
    assign issue_s   = |(req_valid & req_ready);

    // One-hot ready to index of the issuing requester
    always_comb begin
        issue_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            issue_idx_s = req_ready[i] ? IW'(i) : issue_idx_s;
        end
    end

    // Arbitration FSM, round-robin pointer and lock owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_ARB;
            ptr_r   <= IW'(NREQ - 1);
`ifdef FPARB_LOCK_EN
            lock_idx_r <= '0;
`endif
        end else begin
            ptr_r <= issue_s ? issue_idx_s : ptr_r;
`ifdef FPARB_LOCK_EN
            lock_idx_r <= issue_s ? issue_idx_s : lock_idx_r;
`endif
            case (state_r)
                S_ARB: begin
                    if (flush) begin
                        state_r <= S_DRAIN;
`ifdef FPARB_LOCK_EN
                    end else if (issue_s && req_lock[issue_idx_s]) begin
                        state_r <= S_LOCK;
`endif
                    end else begin
                        state_r <= S_ARB;
                    end
                end
`ifdef FPARB_LOCK_EN
                S_LOCK: begin
                    if (flush) begin
                        state_r <= S_DRAIN;
                    end else if (issue_s && !req_lock[lock_idx_r]) begin
                        state_r <= S_ARB;
                    end else begin
                        state_r <= S_LOCK;
                    end
                end
`endif
                S_DRAIN: state_r <= flush ? S_DRAIN : S_ARB;
                default: state_r <= S_ARB;
            endcase
        end
    end

    // Operand launch, tag pipe and response/flush status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_r     <= 2'b00;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            tag_vld_r    <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                tag_idx_r[k] <= '0;
            end
            rsp_valid_r  <= '0;
            flush_done_r <= 1'b0;
        end else begin
            if (issue_s) begin
                alu_op_r <= op_arr_s[issue_idx_s];
                alu_a_r  <= a_arr_s[issue_idx_s];
                alu_b_r  <= b_arr_s[issue_idx_s];
            end else begin
                alu_op_r <= alu_op_r;
                alu_a_r  <= alu_a_r;
                alu_b_r  <= alu_b_r;
            end
            tag_vld_r    <= {tag_vld_r[ALU_LAT-2:0], issue_s};
            tag_idx_r[0] <= issue_idx_s;
            for (int k = 1; k < ALU_LAT; k++) begin
                tag_idx_r[k] <= tag_idx_r[k-1];
            end
            // Last tag stage lines up with alu_y on the following cycle
            rsp_valid_r  <= tag_vld_r[ALU_LAT-1] ? (NREQ'(1'b1) << tag_idx_r[ALU_LAT-1]) : '0;
            flush_done_r <= flush & ~issue_s & ~(|tag_vld_r);
        end
    end

    assign alu_op     = alu_op_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_clk_en = issue_s | (|tag_vld_r);
    assign rsp_valid  = rsp_valid_r;
    assign rsp_y      = alu_y;
    assign flush_done = flush_done_r;

endmodule
